tag_alloc_pool: RTL

//  Free-list allocator for N tags. Keeps a busy bitmap and feeds its free vector to an
//  lzd instance, whose one-hot output picks the lowest-index free tag.

---
 rtl/tag_alloc_pkg.sv | 16 +
 rtl/tag_alloc_pool_if.sv | 30 +++
 rtl/lzd.sv | 12 +
 rtl/onehot_enc.sv | 21 ++
 rtl/tag_alloc_pool.sv | 89 ++++++++
 5 files changed

// File: rtl/tag_alloc_pkg.sv
// Shared width helpers for the tag allocator slice.
package tag_alloc_pkg;

  localparam int unsigned N_DEFAULT = 16;

  // Tag index width; a single-tag pool still needs one bit of index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Free-count width, wide enough to hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tag_alloc_pool_if.sv
// Alloc/free port bundle between a tag pool and its consumer.
interface tag_alloc_pool_if
  import tag_alloc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) ();

  localparam int unsigned W_IDX = idx_width(N);
  localparam int unsigned W_CNT = cnt_width(N);

  logic             o_alloc_vld;
  logic             i_alloc_rdy;
  logic [W_IDX-1:0] o_alloc_idx;
  logic             i_free_vld;
  logic [W_IDX-1:0] i_free_idx;
  logic             i_flush;
  logic [W_CNT-1:0] o_free_cnt;
  logic             o_err_dbl_free;

  modport slave (
    output o_alloc_vld, o_alloc_idx, o_free_cnt, o_err_dbl_free,
    input  i_alloc_rdy, i_free_vld, i_free_idx, i_flush
  );

  modport master (
    input  o_alloc_vld, o_alloc_idx, o_free_cnt, o_err_dbl_free,
    output i_alloc_rdy, i_free_vld, i_free_idx, i_flush
  );

endinterface

// File: rtl/lzd.sv
// Lowest-set-bit detector: one-hot of the lowest-index 1 in vec, zero if none.
module lzd #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot
);

  // Two's-complement trick isolates the least significant set bit.
  assign onehot = vec & (~vec + W'(1));

endmodule

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder; all-zero input encodes to 0.
module onehot_enc
  import tag_alloc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0]              onehot,
  output logic [idx_width(N)-1:0]   idx
);

  localparam int unsigned W_IDX = idx_width(N);

  // OR together the indices of all set bits (exactly one for valid input).
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | W_IDX'(i);
    end
  end

endmodule

// File: rtl/tag_alloc_pool.sv
// Free-list tag allocator: busy bitmap, lowest-free pick, registered offer.
module tag_alloc_pool
  import tag_alloc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  tag_alloc_pool_if.slave bus
);

  localparam int unsigned W_IDX = idx_width(N);
  localparam int unsigned W_CNT = cnt_width(N);

  logic [N-1:0]     busy;
  logic [N-1:0]     busy_next;
  logic [N-1:0]     free_next;
  logic [N-1:0]     alloc_set;
  logic [N-1:0]     free_clr;
  logic [N-1:0]     pick;
  logic [W_IDX-1:0] pick_idx;
  logic [W_CNT-1:0] cnt_next;
  logic             fire;
  logic             free_hit;
  logic             err_next;

  assign fire = bus.o_alloc_vld & bus.i_alloc_rdy;

  // Decode the fired tag and a legal free into bitmap updates.
  always_comb begin
    alloc_set = '0;
    free_clr  = '0;
    for (int i = 0; i < N; i++) begin
      alloc_set[i] = fire && (bus.o_alloc_idx == W_IDX'(i));
      free_clr[i]  = bus.i_free_vld && (bus.i_free_idx == W_IDX'(i)) && busy[i];
    end
  end

  assign free_hit = |free_clr;

  // Next bitmap, count and error; flush overrides any fire or free this cycle.
  always_comb begin
    busy_next = (busy | alloc_set) & ~free_clr;
    cnt_next  = bus.o_free_cnt + W_CNT'(free_hit) - W_CNT'(fire);
    err_next  = bus.i_free_vld & ~free_hit;
    if (bus.i_flush) begin
      busy_next = '0;
      cnt_next  = W_CNT'(N);
      err_next  = 1'b0;
    end
  end

  assign free_next = ~busy_next;

  lzd #(.W(N)) u_lzd (
    .vec    (free_next),
    .onehot (pick)
  );

  onehot_enc #(.N(N)) u_enc (
    .onehot (pick),
    .idx    (pick_idx)
  );

  // Pool state and registered offer; idx holds its last value when exhausted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy               <= '0;
      bus.o_alloc_vld    <= 1'b0;
      bus.o_alloc_idx    <= '0;
      bus.o_free_cnt     <= W_CNT'(N);
      bus.o_err_dbl_free <= 1'b0;
    end else begin
      busy               <= busy_next;
      bus.o_alloc_vld    <= |pick;
      if (|pick) bus.o_alloc_idx <= pick_idx;
      bus.o_free_cnt     <= cnt_next;
      bus.o_err_dbl_free <= err_next;
    end
  end

  a_pick_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(pick))
    else $error("lzd pick is not one-hot");

  a_cnt_matches: assert property (@(posedge i_clk) disable iff (i_rst)
    int'(bus.o_free_cnt) == int'(N) - $countones(busy))
    else $error("free count disagrees with busy bitmap");

endmodule
